sample_extend_sequencer: RTL and testbench

- Shares a single 16-to-24-bit sign-extension datapath between the left and right input sample streams of the MSDAP front end.
- Arbitrates between the two channel requesters and sign-extends each accepted sample (pad bit = sample bit 15).
- Writes the result into the per-channel data-memory ring buffers, managing each channel's write pointer.
- Tracks consecutive zero samples on both channels and raises a sleep status used by the downstream filter controller.

---
 rtl/sample_extend_sequencer_if.sv | 28 ++
 rtl/sample_extend_sequencer.sv | 145 ++++++++++++++
 tb/tb_sample_extend_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_extend_sequencer_if.sv
// Sample-request and data-memory write bus of the sign-extension sequencer.
// The slave modport is the sequencer; the master modport is whatever feeds samples and consumes writes.
interface sample_extend_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid_l;
    logic [15:0]       in_data_l;
    logic              in_ready_l;
    logic              in_valid_r;
    logic [15:0]       in_data_r;
    logic              in_ready_r;
    logic              clear;
    logic              wr_en;
    logic              wr_chan;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              sleep;

    modport slave (
        input  in_valid_l, in_data_l, in_valid_r, in_data_r, clear,
        output in_ready_l, in_ready_r, wr_en, wr_chan, wr_addr, wr_data, sleep
    );

    modport master (
        output in_valid_l, in_data_l, in_valid_r, in_data_r, clear,
        input  in_ready_l, in_ready_r, wr_en, wr_chan, wr_addr, wr_data, sleep
    );
endinterface

// File: rtl/sample_extend_sequencer.sv
// Round-robin L/R sample arbiter feeding one 16->24 sign-extension path into per-channel ring buffers.
// Optional zero-run sleep detection is built only when SEQ_ZERO_SLEEP_EN is defined.
module sample_extend_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int ZERO_RUN = 800,
    parameter int CNT_W    = 10
) (
    input  logic Sclk,
    input  logic Reset,
    sample_extend_sequencer_if.slave bus
);
    if ((2 ** CNT_W) <= ZERO_RUN) begin : g_bad_cnt_w
        $error("CNT_W too narrow for ZERO_RUN");
    end

    logic [1:0]        valid_w;
    logic [1:0][15:0]  data_w;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic              flush;
    logic              acc_any;
    logic              acc_chan;
    logic [15:0]       sel_data;
    logic [23:0]       ext_data;

    logic [1:0][ADDR_W-1:0] ptr_q;
    logic                   last_grant_q;   // 1 = right was granted last
    logic                   wr_en_q;
    logic                   wr_chan_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [23:0]            wr_data_q;

    assign valid_w = {bus.in_valid_r, bus.in_valid_l};
    assign data_w  = {bus.in_data_r, bus.in_data_l};
    assign flush   = Reset | bus.clear;

    always_comb begin
        grant = valid_w;
        if (valid_w == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    assign accept   = grant & {2{~flush}};
    assign acc_any  = |accept;
    assign acc_chan = accept[1];
    assign sel_data = acc_chan ? data_w[1] : data_w[0];
    assign ext_data = {{8{sel_data[15]}}, sel_data};

    assign bus.in_ready_l = accept[0];
    assign bus.in_ready_r = accept[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
        always_ff @(posedge Sclk) begin
            if (flush) begin
                ptr_q[gi] <= '0;
            end else if (accept[gi]) begin
                ptr_q[gi] <= ptr_q[gi] + 1'b1;
            end
        end
    end

    always_ff @(posedge Sclk) begin
        if (flush) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_chan_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            wr_en_q <= acc_any;
            if (acc_any) begin
                last_grant_q <= acc_chan;
                wr_chan_q    <= acc_chan;
                wr_addr_q    <= ptr_q[acc_chan];
                wr_data_q    <= ext_data;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_chan = wr_chan_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

`ifdef SEQ_ZERO_SLEEP_EN
    localparam logic [CNT_W-1:0] ZR_C = CNT_W'(ZERO_RUN);

    typedef enum logic {ST_RUN, ST_SLEEP} state_t;

    state_t                state_q, state_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_zcnt
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (accept[gi]) begin
                if (data_w[gi] != 16'h0000) begin
                    cnt_d[gi] = '0;
                end else if (cnt_q[gi] != ZR_C) begin
                    cnt_d[gi] = cnt_q[gi] + 1'b1;
                end
            end
        end

        always_ff @(posedge Sclk) begin
            if (flush) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    // Sleep decision uses post-update counts so the completing sample's write carries sleep=1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if ((cnt_d[0] == ZR_C) && (cnt_d[1] == ZR_C)) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (acc_any && (sel_data != 16'h0000)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge Sclk) begin
        if (flush) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.sleep = (state_q == ST_SLEEP);
`else
    assign bus.sleep = 1'b0;
`endif
endmodule

// File: tb/tb_sample_extend_sequencer.sv
// Directed bench for sample_extend_sequencer with a spec-level model checked every cycle.
module tb_sample_extend_sequencer;
    localparam int ADDR_W   = 2;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int ZERO_RUN = 4;
    localparam int CNT_W    = 3;
`ifdef SEQ_ZERO_SLEEP_EN
    localparam bit SLP = 1'b1;
`else
    localparam bit SLP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_extend_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    sample_extend_sequencer #(
        .ADDR_W(ADDR_W), .ZERO_RUN(ZERO_RUN), .CNT_W(CNT_W)
    ) dut (
        .Sclk(clk), .Reset(rst), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model state: what the outputs must be in the current cycle, and the bookkeeping behind it.
    bit          model_ok = 1'b0;
    bit          m_wr_en, m_wr_chan, m_sleep;
    int          m_wr_addr;
    logic [23:0] m_wr_data;
    int          m_ptr [2];
    int          m_cnt [2];
    int          m_last;   // channel granted most recently

    always @(negedge clk) begin
        int g;
        logic [15:0] d;
        bit [1:0] v;
        v = {bus.in_valid_r, bus.in_valid_l};
        g = -1;
        if (!rst && !bus.clear) begin
            if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
            else if (v == 2'b11) g = 1 - m_last;
        end
        chk("ready_l", {31'b0, bus.in_ready_l}, {31'b0, g == 0});
        chk("ready_r", {31'b0, bus.in_ready_r}, {31'b0, g == 1});
        if (model_ok) begin
            chk("wr_en",   {31'b0, bus.wr_en},   {31'b0, m_wr_en});
            chk("wr_chan", {31'b0, bus.wr_chan}, {31'b0, m_wr_chan});
            chk("wr_addr", {30'b0, bus.wr_addr}, m_wr_addr);
            chk("wr_data", {8'b0, bus.wr_data},  {8'b0, m_wr_data});
            chk("sleep",   {31'b0, bus.sleep},   {31'b0, m_sleep & SLP});
            if (m_wr_en)
                $display("write chan=%0d addr=%0d data=%06h sleep=%0d",
                         m_wr_chan, m_wr_addr, m_wr_data, m_sleep & SLP);
        end
        if (rst || bus.clear) begin
            model_ok  = 1'b1;
            m_wr_en   = 0; m_wr_chan = 0; m_wr_addr = 0; m_wr_data = '0; m_sleep = 0;
            m_ptr[0]  = 0; m_ptr[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
        end else if (g >= 0) begin
            d = (g == 1) ? bus.in_data_r : bus.in_data_l;
            m_wr_en   = 1;
            m_wr_chan = g[0];
            m_wr_addr = m_ptr[g];
            m_wr_data = 24'($signed(d));
            m_ptr[g]  = (m_ptr[g] + 1) % DEPTH;
            m_cnt[g]  = (d == 0) ? ((m_cnt[g] + 1 > ZERO_RUN) ? ZERO_RUN : m_cnt[g] + 1) : 0;
            m_last    = g;
            if (!m_sleep && m_cnt[0] == ZERO_RUN && m_cnt[1] == ZERO_RUN) m_sleep = 1;
            else if (m_sleep && d != 0) m_sleep = 0;
        end else begin
            m_wr_en = 0;
        end
    end

    task automatic cyc(input bit rs, input bit cl, input bit vl, input logic [15:0] dl,
                       input bit vr, input logic [15:0] dr);
        @(posedge clk);
        #1;
        rst = rs; bus.clear = cl;
        bus.in_valid_l = vl; bus.in_data_l = dl;
        bus.in_valid_r = vr; bus.in_data_r = dr;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.clear = 1'b0;
        bus.in_valid_l = 1'b0; bus.in_data_l = '0;
        bus.in_valid_r = 1'b0; bus.in_data_r = '0;
        cyc(1, 0, 0, 16'h0, 0, 16'h0);
        cyc(1, 0, 0, 16'h0, 0, 16'h0);
        idle();
        chk("rst_wr_en",   {31'b0, bus.wr_en}, 0);
        chk("rst_wr_data", {8'b0, bus.wr_data}, 0);
        chk("rst_sleep",   {31'b0, bus.sleep}, 0);

        // Extremes of the sign extension
        cyc(0, 0, 1, 16'h8000, 0, 16'h0);
        chk("t1_ready_l", {31'b0, bus.in_ready_l}, 1);
        idle();
        chk("t1_wr_en",   {31'b0, bus.wr_en}, 1);
        chk("t1_wr_chan", {31'b0, bus.wr_chan}, 0);
        chk("t1_wr_addr", {30'b0, bus.wr_addr}, 0);
        chk("t1_wr_data", {8'b0, bus.wr_data}, 32'h00FF8000);
        cyc(0, 0, 0, 16'h0, 1, 16'h7FFF);
        idle();
        chk("t1r_wr_chan", {31'b0, bus.wr_chan}, 1);
        chk("t1r_wr_addr", {30'b0, bus.wr_addr}, 0);
        chk("t1r_wr_data", {8'b0, bus.wr_data}, 32'h00007FFF);

        // Continuous dual requests alternate L,R
        cyc(0, 1, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 7; i++) begin
            if (i < 6) cyc(0, 0, 1, 16'h0001, 1, 16'hFFFF);
            else idle();
            if (i < 6) chk("t2_ready_l", {31'b0, bus.in_ready_l}, {31'b0, (i % 2) == 0});
            if (i >= 1) begin
                chk("t2_wr_chan", {31'b0, bus.wr_chan}, (i - 1) % 2);
                chk("t2_wr_addr", {30'b0, bus.wr_addr}, (i - 1) / 2);
                chk("t2_wr_data", {8'b0, bus.wr_data},
                    ((i - 1) % 2) ? 32'h00FFFFFF : 32'h00000001);
            end
        end

        // Left pointer wraps, right pointer untouched
        cyc(0, 1, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) cyc(0, 0, 1, 16'h1234 + 16'(i), 0, 16'h0);
            else idle();
            if (i >= 1) chk("t3_wr_addr", {30'b0, bus.wr_addr}, (i - 1) % 4);
        end
        cyc(0, 0, 0, 16'h0, 1, 16'h0055);
        idle();
        chk("t3r_wr_addr", {30'b0, bus.wr_addr}, 0);
        chk("t3r_wr_chan", {31'b0, bus.wr_chan}, 1);

        // Zero run on both channels, woken by a right nonzero sample
        cyc(0, 1, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) cyc(0, 0, 1, 16'h0, 1, 16'h0);
            else if (i == 8) cyc(0, 0, 0, 16'h0, 1, 16'h0002);
            else idle();
            if (i >= 1) chk("t4_sleep", {31'b0, bus.sleep}, {31'b0, SLP && (i == 8)});
        end
        chk("t4_wr_data", {8'b0, bus.wr_data}, 32'h00000002);
        chk("t4_wr_chan", {31'b0, bus.wr_chan}, 1);

        // Nonzero left sample restarts its run
        cyc(0, 1, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 13; i++) begin
            if (i < 3) cyc(0, 0, 1, 16'h0, 0, 16'h0);
            else if (i == 3) cyc(0, 0, 1, 16'h0010, 0, 16'h0);
            else if (i < 12) cyc(0, 0, 1, 16'h0, 1, 16'h0);
            else idle();
            if (i >= 1) chk("t5_sleep", {31'b0, bus.sleep}, {31'b0, SLP && (i == 12)});
        end

        // clear cancels the accept and the pending write
        cyc(0, 0, 1, 16'h0005, 0, 16'h0);
        cyc(0, 1, 1, 16'h0006, 0, 16'h0);
        chk("t6_ready_l", {31'b0, bus.in_ready_l}, 0);
        idle();
        chk("t6_wr_en", {31'b0, bus.wr_en}, 0);
        cyc(0, 0, 1, 16'h0007, 0, 16'h0);
        idle();
        chk("t6_wr_en2",  {31'b0, bus.wr_en}, 1);
        chk("t6_wr_addr", {30'b0, bus.wr_addr}, 0);
        chk("t6_sleep",   {31'b0, bus.sleep}, 0);

        // Reset mid-stream behaves like clear
        cyc(0, 0, 1, 16'h0009, 0, 16'h0);
        cyc(1, 0, 1, 16'h000A, 1, 16'h000B);
        chk("t7_ready_l", {31'b0, bus.in_ready_l}, 0);
        idle();
        chk("t7_wr_en",   {31'b0, bus.wr_en}, 0);
        chk("t7_wr_addr", {30'b0, bus.wr_addr}, 0);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
